// File: rtl/lcd_stream_gen.sv
// Pixel stream conditioner between the PPU and the LCD scan converter:
// enforces exact line length, bounds frame height and hides the first frame after power-on.
module lcd_stream_gen #(
    parameter int unsigned W     = 160,
    parameter int unsigned LINES = 144,
    parameter logic [14:0] FILL  = 15'h7FFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        lcd_en,
    input  logic [1:0]  ppu_mode,
    input  logic        pix_valid,
    input  logic [14:0] pix_data,
    output logic        lcd_clkena,
    output logic [14:0] lcd_data,
    output logic [1:0]  lcd_mode,
    output logic        lcd_on,
    output logic        frame_done,
    output logic        err_short,
    output logic        err_long
);

    typedef enum logic [1:0] {S_OFF, S_SKIP, S_ACTIVE, S_PAD} state_t;

    localparam logic [7:0] WX = 8'(W);
    localparam logic [7:0] LY = 8'(LINES);

    state_t      state;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [1:0]  mode_d;

    logic        vblank_entry;
    logic        hblank_entry;
    logic        take;
    logic [7:0]  x_acc;
    logic [7:0]  x_pad;
    logic [7:0]  y_inc;

    always_comb begin
        vblank_entry = (ppu_mode == 2'd1) && (mode_d != 2'd1);
        hblank_entry = (ppu_mode == 2'd0) && (mode_d == 2'd3);
        take         = pix_valid && (x < WX) && (y < LY);
        // a pixel arriving with the hblank edge counts before the completeness check
        x_acc        = take ? x + 8'd1 : x;
        x_pad        = x + 8'd1;
        y_inc        = (y >= LY) ? LY : y + 8'd1;
    end

    always_ff @(posedge clk) begin
        mode_d <= ppu_mode;
        if (!reset_n) begin
            state      <= S_OFF;
            x          <= '0;
            y          <= '0;
            lcd_clkena <= 1'b0;
            lcd_data   <= '0;
            lcd_mode   <= 2'd1;
            lcd_on     <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
        end else begin
            lcd_clkena <= 1'b0;
            frame_done <= 1'b0;
            if (!lcd_en) begin
                state    <= S_OFF;
                x        <= '0;
                y        <= '0;
                lcd_on   <= 1'b0;
                lcd_mode <= 2'd1;
                lcd_data <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        lcd_on   <= 1'b0;
                        lcd_mode <= 2'd1;
                        x        <= '0;
                        y        <= '0;
                        state    <= S_SKIP;
                    end
                    S_SKIP: begin
                        lcd_mode <= 2'd1;
                        if (vblank_entry) begin
                            state    <= S_ACTIVE;
                            lcd_on   <= 1'b1;
                            lcd_mode <= ppu_mode;
                            x        <= '0;
                            y        <= '0;
                        end else begin
                            lcd_on <= 1'b0;
                        end
                    end
                    S_ACTIVE: begin
                        lcd_on   <= 1'b1;
                        lcd_mode <= ppu_mode;
                        if (take) begin
                            lcd_clkena <= 1'b1;
                            lcd_data   <= pix_data;
                        end else if (pix_valid) begin
                            err_long <= 1'b1;
                        end
                        if (vblank_entry) begin
                            x          <= '0;
                            y          <= '0;
                            frame_done <= 1'b1;
                        end else if (hblank_entry && x_acc == WX) begin
                            x <= '0;
                            y <= y_inc;
                        end else if (hblank_entry && x_acc != 8'd0) begin
                            state     <= S_PAD;
                            err_short <= 1'b1;
                            lcd_mode  <= 2'd0;
                            x         <= x_acc;
                        end else begin
                            x <= x_acc;
                        end
                    end
                    S_PAD: begin
                        lcd_on <= 1'b1;
                        if (pix_valid)
                            err_long <= 1'b1;
                        if (vblank_entry) begin
                            state      <= S_ACTIVE;
                            lcd_mode   <= ppu_mode;
                            err_short  <= 1'b1;
                            x          <= '0;
                            y          <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            lcd_mode <= 2'd0;
                            if (ce) begin
                                lcd_clkena <= 1'b1;
                                lcd_data   <= FILL;
                                if (x_pad >= WX) begin
                                    state    <= S_ACTIVE;
                                    lcd_mode <= ppu_mode;
                                    x        <= '0;
                                    y        <= y_inc;
                                end else begin
                                    x <= x_pad;
                                end
                            end
                        end
                    end
                    default: state <= S_OFF;
                endcase
            end
        end
    end

endmodule
